run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_run_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - eight-segment timed program sequencer with pause/hold, abort and actuator decode
module run_sequencer #(
  parameter logic [2:0] RUN_CODE   = 3'd3,
  parameter logic [2:0] ERR_CODE   = 3'd4,
  parameter logic [2:0] PAUSE_CODE = 3'd5
) (
  input  logic        cp,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [2:0]  state,
  input  logic [25:0] sourceData,
  output logic [2:0]  seg,
  output logic [3:0]  remain,
  output logic [6:0]  totalRemain,
  output logic        inValve,
  output logic        outValve,
  output logic        motorWash,
  output logic        motorSpin,
  output logic        finishReq
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEEK = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] LAST_SEG = 3'd7;

  logic [2:0]  fsm, fsm_next;
  logic [25:0] prog, prog_next;
  logic [2:0]  seg_next;
  logic [3:0]  remain_next;
  logic [6:0]  total_next;

  logic        cmd_run;
  logic        cmd_hold;
  logic        cmd_abort;
  logic [3:0]  cur_field;

  // Duration of segment s inside a program word; 3-bit fields are zero-extended.
  function automatic logic [3:0] field_of(input logic [25:0] w, input logic [2:0] s);
    logic [3:0] f;
    case (s)
      3'd0:    f = {1'b0, w[25:23]};
      3'd1:    f = w[22:19];
      3'd2:    f = {1'b0, w[18:16]};
      3'd3:    f = {1'b0, w[15:13]};
      3'd4:    f = {1'b0, w[12:10]};
      3'd5:    f = w[9:6];
      3'd6:    f = {1'b0, w[5:3]};
      default: f = {1'b0, w[2:0]};
    endcase
    return f;
  endfunction

  // Whole-program duration; 72 at most, so 7 bits never overflow.
  function automatic logic [6:0] field_sum(input logic [25:0] w);
    logic [6:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'b000, field_of(w, i[2:0])};
    end
    return acc;
  endfunction

  assign cmd_run   = (state == RUN_CODE);
  assign cmd_hold  = (state == PAUSE_CODE) || (state == ERR_CODE);
  assign cmd_abort = !(cmd_run || cmd_hold);
  assign cur_field = field_of(prog, seg);

  // Next-state and counter update; abort is checked first so it beats any segment activity.
  always_comb begin
    fsm_next    = fsm;
    prog_next   = prog;
    seg_next    = seg;
    remain_next = remain;
    total_next  = totalRemain;
    case (fsm)
      S_IDLE: begin
        if (cmd_run) begin
          prog_next   = sourceData;
          seg_next    = 3'd0;
          remain_next = 4'd0;
          total_next  = field_sum(sourceData);
          fsm_next    = S_SEEK;
        end
      end
      S_SEEK: begin
        if (cmd_abort) begin
          fsm_next    = S_IDLE;
          seg_next    = 3'd0;
          remain_next = 4'd0;
          total_next  = 7'd0;
        end else if (cur_field == 4'd0) begin
          if (seg == LAST_SEG) begin
            fsm_next = S_DONE;
            seg_next = 3'd0;
          end else begin
            seg_next = seg + 3'd1;
          end
        end else begin
          remain_next = cur_field;
          fsm_next    = S_RUN;
        end
      end
      S_RUN: begin
        if (cmd_abort) begin
          fsm_next    = S_IDLE;
          seg_next    = 3'd0;
          remain_next = 4'd0;
          total_next  = 7'd0;
        end else if (cmd_hold) begin
          // Pause wins over a coincident tick: nothing is counted on entry.
          fsm_next = S_HOLD;
        end else if (tick) begin
          remain_next = remain - 4'd1;
          total_next  = totalRemain - 7'd1;
          if (remain == 4'd1) begin
            if (seg == LAST_SEG) begin
              fsm_next = S_DONE;
              seg_next = 3'd0;
            end else begin
              fsm_next = S_SEEK;
              seg_next = seg + 3'd1;
            end
          end
        end
      end
      S_HOLD: begin
        if (cmd_abort) begin
          fsm_next    = S_IDLE;
          seg_next    = 3'd0;
          remain_next = 4'd0;
          total_next  = 7'd0;
        end else if (cmd_run) begin
          fsm_next = S_RUN;
        end
      end
      S_DONE: begin
        if (!cmd_run) begin
          fsm_next    = S_IDLE;
          seg_next    = 3'd0;
          remain_next = 4'd0;
          total_next  = 7'd0;
        end
      end
      default: begin
        fsm_next    = S_IDLE;
        seg_next    = 3'd0;
        remain_next = 4'd0;
        total_next  = 7'd0;
      end
    endcase
  end

  // State and counter registers; reset overrides everything including a pending tick.
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      fsm         <= S_IDLE;
      prog        <= '0;
      seg         <= 3'd0;
      remain      <= 4'd0;
      totalRemain <= 7'd0;
    end else begin
      fsm         <= fsm_next;
      prog        <= prog_next;
      seg         <= seg_next;
      remain      <= remain_next;
      totalRemain <= total_next;
    end
  end

  // Actuators come only from registered state and seg; segments 0/4 fill, 1/5 wash, 2/3/6/7 drain, 3/7 spin.
  assign inValve   = (fsm == S_RUN) && (seg[1:0] == 2'd0);
  assign motorWash = (fsm == S_RUN) && (seg[1:0] == 2'd1);
  assign outValve  = (fsm == S_RUN) && seg[1];
  assign motorSpin = (fsm == S_RUN) && (seg[1:0] == 2'd3);
  assign finishReq = (fsm == S_DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized self-checking bench for run_sequencer against a segment-list model
module tb_run_sequencer;

  logic        cp = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [2:0]  state;
  logic [25:0] sourceData;
  logic [2:0]  seg;
  logic [3:0]  remain;
  logic [6:0]  totalRemain;
  logic        inValve, outValve, motorWash, motorSpin, finishReq;

  int checks = 0;
  int errors = 0;

  run_sequencer dut (
    .cp(cp), .rst_n(rst_n), .tick(tick), .state(state), .sourceData(sourceData),
    .seg(seg), .remain(remain), .totalRemain(totalRemain),
    .inValve(inValve), .outValve(outValve), .motorWash(motorWash),
    .motorSpin(motorSpin), .finishReq(finishReq)
  );

  always #5 cp = ~cp;

  // Reference model: a list of per-segment time left, a pointer and a coarse phase.
  typedef enum int {P_IDLE, P_SEEK, P_RUN, P_HOLD, P_DONE} phase_t;
  localparam int WID [8] = '{3, 4, 3, 3, 3, 4, 3, 3};
  int     left [8];
  int     pos;
  phase_t ph;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int field_lo(input int k);
    int hi = 25;
    for (int j = 0; j < k; j++) hi -= WID[j];
    return hi - WID[k] + 1;
  endfunction

  function automatic int field_at(input logic [25:0] w, input int k);
    int word = int'(w);
    return (word >> field_lo(k)) & ((1 << WID[k]) - 1);
  endfunction

  function automatic int total_left();
    int s = 0;
    for (int k = 0; k < 8; k++) s += left[k];
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) left[k] = 0;
    pos = 0;
    ph  = P_IDLE;
  endtask

  task automatic model_step(input logic [2:0] st, input logic tk, input logic rs, input logic [25:0] sd);
    bit go    = (st == 3'd3);
    bit hold  = (st == 3'd4) || (st == 3'd5);
    bit abort = !(go || hold);
    if (!rs) begin
      model_clear();
      return;
    end
    case (ph)
      P_IDLE: if (go) begin
        for (int k = 0; k < 8; k++) left[k] = field_at(sd, k);
        pos = 0;
        ph  = P_SEEK;
      end
      P_SEEK: begin
        if (abort) model_clear();
        else if (left[pos] != 0) ph = P_RUN;
        else if (pos == 7) begin ph = P_DONE; pos = 0; end
        else pos++;
      end
      P_RUN: begin
        if (abort) model_clear();
        else if (hold) ph = P_HOLD;
        else if (tk) begin
          left[pos]--;
          if (left[pos] == 0) begin
            if (pos == 7) begin ph = P_DONE; pos = 0; end
            else begin ph = P_SEEK; pos++; end
          end
        end
      end
      P_HOLD: begin
        if (abort) model_clear();
        else if (go) ph = P_RUN;
      end
      default: if (!go) model_clear();
    endcase
  endtask

  task automatic compare();
    bit run = (ph == P_RUN);
    logic [4:0] act;
    act[4] = run && (pos == 0 || pos == 4);
    act[3] = run && (pos == 2 || pos == 3 || pos == 6 || pos == 7);
    act[2] = run && (pos == 1 || pos == 5);
    act[1] = run && (pos == 3 || pos == 7);
    act[0] = (ph == P_DONE);
    check("seg", seg, pos);
    check("remain", remain, (run || ph == P_HOLD) ? left[pos] : 0);
    check("totalRemain", totalRemain, total_left());
    check("actuators", {inValve, outValve, motorWash, motorSpin, finishReq}, act);
    check("valve_excl", inValve & outValve, 0);
  endtask

  task automatic cyc(input logic [2:0] st, input logic tk, input logic rs, input logic [25:0] sd);
    state = st; tick = tk; rst_n = rs; sourceData = sd;
    @(posedge cp);
    model_step(st, tk, rs, sd);
    #1 compare();
  endtask

  function automatic logic [25:0] rnd_word();
    logic [31:0] r = $urandom();
    return r[25:0];
  endfunction

  function automatic logic [25:0] rnd_prog();
    logic [25:0] w = rnd_word();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1, 0) == 0) w = w & ~(26'((1 << WID[k]) - 1) << field_lo(k));
    end
    return w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check(tag, {seg, remain, totalRemain, inValve, outValve, motorWash, motorSpin, finishReq}, 0);
  endtask

  initial begin
    bit found;
    model_clear();
    state = 3'd0; tick = 1'b0; rst_n = 1'b0; sourceData = '0;

    // Reset state and idling on non-run codes.
    cyc(3'd0, 1'b1, 1'b0, rnd_word());
    check_idle_outputs("reset_outputs");
    cyc(3'd5, 1'b1, 1'b1, rnd_word());
    cyc(3'd4, 1'b0, 1'b1, rnd_word());
    cyc(3'd1, 1'b1, 1'b1, rnd_word());
    check_idle_outputs("idle_until_run");

    // Drain-only program: six skipped segments, then seg6 for four ticks and seg7 for five.
    cyc(3'd3, 1'b0, 1'b1, 26'h0000025);
    check("drain_total_load", totalRemain, 9);
    for (int i = 0; i < 7; i++) cyc(3'd3, 1'b0, 1'b1, rnd_word());
    check("drain_seg6", {seg, remain, outValve}, {3'd6, 4'd4, 1'b1});
    for (int i = 0; i < 9; i++) begin
      cyc(3'd3, 1'b1, 1'b1, rnd_word());
      if (ph == P_SEEK) cyc(3'd3, 1'b0, 1'b1, rnd_word());
    end
    check("drain_finish", finishReq, 1);
    cyc(3'd0, 1'b0, 1'b1, rnd_word());

    // Pause inside seg1 at remain 6, ticks ignored while paused.
    cyc(3'd3, 1'b0, 1'b1, 26'h0EA5C25);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(3'd3, 1'b1, 1'b1, rnd_word());
      found = (ph == P_RUN && pos == 1 && left[1] == 6);
    end
    check("reach_seg1_rem6", found, 1);
    for (int i = 0; i < 20; i++) cyc(3'd5, 1'b1, 1'b1, rnd_word());
    cyc(3'd3, 1'b0, 1'b1, rnd_word());
    check("resume_after_pause", {remain, motorWash}, {4'd6, 1'b1});

    // Abort during seg4, then a fresh run restarts at seg0.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(3'd3, 1'b1, 1'b1, rnd_word());
      found = (ph == P_RUN && pos == 4);
    end
    check("reach_seg4", found, 1);
    cyc(3'd1, 1'b1, 1'b1, rnd_word());
    check_idle_outputs("abort_outputs");
    cyc(3'd3, 1'b0, 1'b1, 26'h0EA5C25);
    check("restart_seg0", seg, 0);

    // Reset mid-RUN with a tick pending.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc(3'd3, 1'b0, 1'b1, rnd_word());
      found = (ph == P_RUN);
    end
    check("reach_run", found, 1);
    cyc(3'd3, 1'b1, 1'b0, rnd_word());
    check_idle_outputs("reset_mid_run");

    // Empty program: eight SEEK cycles then DONE, never any actuator.
    cyc(3'd3, 1'b0, 1'b1, 26'h0000000);
    for (int i = 0; i < 7; i++) cyc(3'd3, 1'b1, 1'b1, rnd_word());
    check("empty_not_yet_done", finishReq, 0);
    cyc(3'd3, 1'b1, 1'b1, rnd_word());
    check("empty_done", {finishReq, seg, totalRemain}, {1'b1, 3'd0, 7'd0});
    cyc(3'd5, 1'b0, 1'b1, rnd_word());
    check("done_exit", finishReq, 0);

    // Randomized programs with pauses, errors, aborts and occasional reset.
    for (int run_i = 0; run_i < 60; run_i++) begin
      cyc(3'd0, 1'b0, 1'b1, rnd_word());
      cyc(3'd3, 1'($urandom_range(1, 0)), 1'b1, rnd_prog());
      for (int n = 0; n < 400 && ph != P_IDLE; n++) begin
        int r = $urandom_range(99, 0);
        logic [2:0] st;
        st = (r < 88) ? 3'd3 : (r < 93) ? 3'd5 : (r < 97) ? 3'd4 : (r < 99) ? 3'(r % 3 == 0 ? 1 : 6) : 3'd3;
        if (ph == P_DONE && $urandom_range(3, 0) == 0) st = 3'd0;
        cyc(st, 1'($urandom_range(1, 0)), (r == 99) ? 1'b0 : 1'b1, rnd_word());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
